pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage ARM-subset core. It generates the freeze and flush controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers from three sources: the hazard detector, the EXE-stage branch decision, and the SRAM memory handshake. A small FSM tracks multi-cycle memory waits, enforces a wait timeout that latches a sticky fault, and optionally keeps performance counters.

---
 rtl/pipe_ctrl_if.sv | 35 +++
 rtl/pipe_ctrl.sv | 121 ++++++++++++
 tb/tb_pipe_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pipe_ctrl_if : hazard/branch/memory inputs and stage controls      |
// | Revision     : 1.0                                                 |
// +------------------------------------------------------------------+
interface pipe_ctrl_if;
  logic        hazard;
  logic        branch_taken;
  logic        mem_req;
  logic        mem_ready;
  logic        freeze_pc;
  logic        freeze_ifid;
  logic        freeze_back;
  logic        flush_ifid;
  logic        flush_idex;
  logic        fault;
  logic [31:0] stall_cnt;
  logic [31:0] memwait_cnt;
  logic [31:0] flush_cnt;

  // Pipeline side: raises the requests, consumes the controls.
  modport master (
    output hazard, branch_taken, mem_req, mem_ready,
    input  freeze_pc, freeze_ifid, freeze_back, flush_ifid, flush_idex,
    input  fault, stall_cnt, memwait_cnt, flush_cnt
  );

  // Controller side.
  modport slave (
    input  hazard, branch_taken, mem_req, mem_ready,
    output freeze_pc, freeze_ifid, freeze_back, flush_ifid, flush_idex,
    output fault, stall_cnt, memwait_cnt, flush_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pipe_ctrl : freeze/flush sequencing with memory-wait timeout FSM.  |
// | Optional perf counters: define PIPE_CTRL_PERF_EN.                  |
// | Revision  : 1.0                                                    |
// +------------------------------------------------------------------+
module pipe_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int WAIT_W  = 8
) (
  input  logic          clk,
  input  logic          rst,
  pipe_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } state_t;

  localparam bit                TO_EN  = (TIMEOUT != 0);
  localparam int                TO_M1  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [WAIT_W-1:0] TO_LIM = WAIT_W'(TO_M1);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic mstall;
  logic row_fault, row_mstall, row_branch, row_hazard;

  // Priority decode: fault > memory stall > branch > hazard.
  assign mstall     = bus.mem_req & ~bus.mem_ready;
  assign row_fault  = (state_q == FAULT);
  assign row_mstall = ~row_fault & mstall;
  assign row_branch = ~row_fault & ~mstall & bus.branch_taken;
  assign row_hazard = ~row_fault & ~mstall & ~bus.branch_taken & bus.hazard;

  assign bus.freeze_pc   = ~rst & (row_fault | row_mstall | row_hazard);
  assign bus.freeze_ifid = ~rst & (row_fault | row_mstall | row_hazard);
  assign bus.freeze_back = ~rst & (row_fault | row_mstall);
  assign bus.flush_ifid  = ~rst & row_branch;
  assign bus.flush_idex  = ~rst & (row_branch | row_hazard);
  assign bus.fault       = ~rst & row_fault;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      RUN: begin
        if (mstall) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (!mstall) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (TO_EN && (wait_cnt_q >= TO_LIM)) begin
          // >= rather than == so TIMEOUT=1 still trips on the second stall cycle.
          state_d    = FAULT;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] memwait_cnt_q, memwait_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d   = stall_cnt_q   + {31'd0, row_hazard};
    memwait_cnt_d = memwait_cnt_q + {31'd0, row_mstall};
    flush_cnt_d   = flush_cnt_q   + {31'd0, row_branch};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q   <= '0;
      memwait_cnt_q <= '0;
      flush_cnt_q   <= '0;
    end else begin
      stall_cnt_q   <= stall_cnt_d;
      memwait_cnt_q <= memwait_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.memwait_cnt = memwait_cnt_q;
  assign bus.flush_cnt   = flush_cnt_q;
`else
  assign bus.stall_cnt   = 32'd0;
  assign bus.memwait_cnt = 32'd0;
  assign bus.flush_cnt   = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_pipe_ctrl : vector table, corner sequences and random run       |
// | against a priority/stall-run reference model.                      |
// | Revision     : 1.0                                                 |
// +------------------------------------------------------------------+
module tb_pipe_ctrl;

  localparam int T = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_ctrl_if bus();

  pipe_ctrl #(.TIMEOUT(T), .WAIT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: sticky fault, length of the current stall run, counters.
  bit          m_fault;
  int          m_run;
  int unsigned m_stall, m_memw, m_flush;

  // Ctrl vector bit order: {freeze_pc, freeze_ifid, freeze_back, flush_ifid, flush_idex, fault}
  function automatic logic [5:0] model_ctrl(input logic h, b, req, rdy, flt, r);
    if (r)            return 6'b000000;
    if (flt)          return 6'b111001;
    if (req && !rdy)  return 6'b111000;
    if (b)            return 6'b000110;
    if (h)            return 6'b110010;
    return 6'b000000;
  endfunction

  function automatic logic [95:0] model_cnts();
`ifdef PIPE_CTRL_PERF_EN
    return {m_stall, m_memw, m_flush};
`else
    return 96'd0;
`endif
  endfunction

  task automatic model_reset();
    m_fault = 1'b0; m_run = 0; m_stall = 0; m_memw = 0; m_flush = 0;
  endtask

  task automatic model_edge();
    logic mst;
    mst = bus.mem_req & ~bus.mem_ready;
    if (rst) begin
      model_reset();
    end else if (!m_fault) begin
      if (mst) begin
        m_memw++;
        m_run++;
        if (T != 0 && m_run >= ((T < 2) ? 2 : T)) m_fault = 1'b1;
      end else begin
        m_run = 0;
        if (bus.branch_taken)  m_flush++;
        else if (bus.hazard)   m_stall++;
      end
    end
  endtask

  task automatic check(input string tag, input bit use_exp, input logic [5:0] exp_v);
    logic [5:0]  act, want;
    logic [95:0] act_c, want_c;
    act  = {bus.freeze_pc, bus.freeze_ifid, bus.freeze_back,
            bus.flush_ifid, bus.flush_idex, bus.fault};
    want = use_exp ? exp_v
                   : model_ctrl(bus.hazard, bus.branch_taken, bus.mem_req,
                                bus.mem_ready, m_fault, rst);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s ctrl: got %b want %b", tag, act, want);
    end
    act_c  = {bus.stall_cnt, bus.memwait_cnt, bus.flush_cnt};
    want_c = model_cnts();
    n_cmp++;
    if (act_c !== want_c) begin
      n_bad++;
      $display("FAIL %s cnts: got %0d/%0d/%0d want %0d/%0d/%0d", tag,
               act_c[95:64], act_c[63:32], act_c[31:0],
               want_c[95:64], want_c[63:32], want_c[31:0]);
    end
  endtask

  // Entered just after a rising edge; returns just after the next one.
  task automatic step(input logic h, b, req, rdy, input string tag,
                      input bit use_exp = 1'b0, input logic [5:0] exp_v = 6'b0);
    bus.hazard = h; bus.branch_taken = b; bus.mem_req = req; bus.mem_ready = rdy;
    @(negedge clk);
    check(tag, use_exp, exp_v);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.hazard = 1'b1; bus.branch_taken = 1'b0; bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
    model_reset();
    #1;
    check("reset", 1'b1, 6'b000000);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.hazard = 1'b0; bus.mem_req = 1'b0;
  endtask

  function automatic logic [31:0] delta(input logic [31:0] now_v, input logic [31:0] then_v);
    return now_v - then_v;
  endfunction

  task automatic check_delta(input string tag, input logic [31:0] got, input int unsigned want_perf);
    logic [31:0] want;
`ifdef PIPE_CTRL_PERF_EN
    want = want_perf;
`else
    want = 32'd0;
`endif
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  typedef struct {
    logic       h, b, req, rdy;
    logic [5:0] exp_v;
  } vec_t;

  vec_t        tbl[9];
  logic [31:0] c0;
  int unsigned fault_age;
  int          bias;

  initial begin
    rst = 1'b0;
    bus.hazard = 1'b0; bus.branch_taken = 1'b0; bus.mem_req = 1'b0; bus.mem_ready = 1'b0;
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'b110010};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 6'b000110};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 6'b000110};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 6'b000000};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 6'b110010};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 6'b111000};
    tbl[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 6'b111000};
    tbl[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 6'b000110};

    #2;
    do_reset();

    for (int i = 0; i < 9; i++)
      step(tbl[i].h, tbl[i].b, tbl[i].req, tbl[i].rdy, $sformatf("tbl%0d", i), 1'b1, tbl[i].exp_v);
    step(0, 0, 0, 0, "tbl_idle", 1'b1, 6'b000000);

    // Two hazard cycles: one bubble each, back end keeps moving.
    c0 = bus.stall_cnt;
    step(1, 0, 0, 0, "haz_c1", 1'b1, 6'b110010);
    step(1, 0, 0, 0, "haz_c2", 1'b1, 6'b110010);
    step(0, 0, 0, 0, "haz_end", 1'b1, 6'b000000);
    check_delta("haz_stall_cnt", delta(bus.stall_cnt, c0), 2);

    // Branch beats a concurrent hazard.
    c0 = bus.flush_cnt;
    step(1, 1, 0, 0, "br_haz", 1'b1, 6'b000110);
    step(0, 0, 0, 0, "br_end", 1'b1, 6'b000000);
    check_delta("br_flush_cnt", delta(bus.flush_cnt, c0), 1);

    // Branch held through a 3-cycle memory stall, applied on release.
    c0 = bus.memwait_cnt;
    for (int i = 0; i < 3; i++)
      step(0, 1, 1, 0, $sformatf("mw_br%0d", i), 1'b1, 6'b111000);
    step(0, 1, 1, 1, "mw_release", 1'b1, 6'b000110);
    step(1, 0, 0, 0, "mw_run_again", 1'b1, 6'b110010);
    check_delta("mw_memwait_cnt", delta(bus.memwait_cnt, c0), 3);

    // Zero-wait access leaves the memory-wait count alone.
    c0 = bus.memwait_cnt;
    step(0, 0, 1, 1, "zero_wait", 1'b1, 6'b000000);
    check_delta("zero_wait_cnt", delta(bus.memwait_cnt, c0), 0);

    // Timeout: four stalled cycles without fault, fault from the fifth on.
    do_reset();
    for (int i = 1; i <= 4; i++)
      step(0, 0, 1, 0, $sformatf("to_stall%0d", i), 1'b1, 6'b111000);
    step(0, 0, 1, 0, "to_fault5", 1'b1, 6'b111001);
    step(0, 0, 1, 1, "to_ready", 1'b1, 6'b111001);
    step(1, 1, 0, 0, "to_sticky", 1'b1, 6'b111001);

    // Asynchronous reset in FAULT, released between edges.
    bus.hazard = 1'b1; bus.branch_taken = 1'b0; bus.mem_req = 1'b0; bus.mem_ready = 1'b0;
    #2 rst = 1'b1;
    model_reset();
    #1 check("async_rst", 1'b1, 6'b000000);
    #1 rst = 1'b0;
    #1 check("post_rst_run", 1'b1, 6'b110010);
    @(posedge clk); model_edge(); #1;
    step(0, 1, 0, 0, "post_rst_br", 1'b1, 6'b000110);

    // Random traffic against the reference model.
    fault_age = 0;
    bias = 8;
    for (int i = 0; i < 600; i++) begin
      if (i % 40 == 0) bias = (bias == 8) ? 2 : 8;
      if (m_fault) fault_age++;
      if (fault_age > 3) begin
        fault_age = 0;
        do_reset();
      end
      step($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 9) < bias,
           $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
